// File: rtl/store_merge_unit_pkg.sv
// Shared store definitions: size codes, FSM state type, read-latency bounds
// and lane/alignment helpers used by the store engine and the control unit.
package store_pkg;

  localparam logic [1:0] TAM_SD = 2'b00;
  localparam logic [1:0] TAM_SW = 2'b01;
  localparam logic [1:0] TAM_SH = 2'b10;
  localparam logic [1:0] TAM_SB = 2'b11;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } store_state_t;

  // Byte-enable pattern of a store of the given size, anchored at byte 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] tam);
    case (tam)
      TAM_SD:  return 8'hFF;
      TAM_SW:  return 8'h0F;
      TAM_SH:  return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] tam, input logic [2:0] off);
    case (tam)
      TAM_SD:  return off == 3'd0;
      TAM_SW:  return off[1:0] == 2'd0;
      TAM_SH:  return !off[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Request/memory bus of the store engine; slave is the engine side,
// master is the control-unit/memory side.
interface store_merge_unit_if;
  logic        DMemWrite;
  logic [1:0]  tam;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_rdata;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        align_err;

  modport slave (
    input  DMemWrite, tam, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, align_err
  );

  modport master (
    output DMemWrite, tam, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, align_err
  );
endinterface

// File: rtl/store_merge_unit_merge.sv
// Little-endian byte-lane replacement: writes the low bytes of new_data into
// old_data starting at byte offset off, size chosen by tam.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [63:0] old_data,
  input  logic [63:0] new_data,
  input  logic [1:0]  tam,
  input  logic [2:0]  off,
  output logic [63:0] merged
);

  logic [7:0]  byte_en;
  logic [63:0] shifted;
  logic [63:0] bit_en;

  always_comb begin
    byte_en = lane_mask(tam) << off;
    shifted = new_data << {off, 3'b000};
    bit_en  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      bit_en[8*i +: 8] = {8{byte_en[i]}};
    end
    merged = (old_data & ~bit_en) | (shifted & bit_en);
  end

endmodule

// File: rtl/store_merge_unit.sv
// Multicycle store engine: direct doubleword writes, read-modify-write for
// narrower stores, and a dropped-with-pulse path for misaligned requests.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input logic clk,
  input logic reset,
  store_merge_unit_if.slave bus
);

  localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [1:0] LAT_CNT = 2'(LAT);

  store_state_t state;
  logic [1:0]   cnt;
  logic [1:0]   tam_q;
  logic [63:0]  addr_q;
  logic [63:0]  wdata_q;
  logic [63:0]  old_q;
  logic [63:0]  merged;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tam_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bus.DMemWrite) begin
            tam_q   <= bus.tam;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            if (!is_aligned(bus.tam, bus.addr[2:0])) state <= ST_ERR;
            else if (bus.tam == TAM_SD)              state <= ST_WRITE;
            else                                     state <= ST_READ;
          end
        end
        // Counter spans 0..LAT so the address is held LAT+1 cycles before capture.
        ST_READ: begin
          if (cnt == LAT_CNT) begin
            old_q <= bus.mem_rdata;
            cnt   <= '0;
            state <= ST_WRITE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        ST_WRITE: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        ST_ERR:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  byte_lane_merge u_merge (
    .old_data (old_q),
    .new_data (wdata_q),
    .tam      (tam_q),
    .off      (addr_q[2:0]),
    .merged   (merged)
  );

  // Outputs decode the registered state only, so reset clears them at once
  // and a write strobe is either fully present or absent.
  assign bus.mem_addr  = (state == ST_READ || state == ST_WRITE) ? {addr_q[63:3], 3'b000} : '0;
  assign bus.mem_wdata = (state != ST_WRITE) ? '0 : (tam_q == TAM_SD) ? wdata_q : merged;
  assign bus.mem_wr    = (state == ST_WRITE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.align_err = (state == ST_ERR);

endmodule
